// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared sizes, types and writeback port numbering for the ROB controller
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ALLOC_W   = 4;
  localparam int COMMIT_W  = 2;
  localparam int PTR_W     = 4;
  localparam int CNT_W     = 5;
  localparam int RT_W      = 4;
  localparam int VAL_W     = 16;
  localparam int NUM_WB    = 4;

  localparam int WB_FXU0 = 0;
  localparam int WB_FXU1 = 1;
  localparam int WB_LSU  = 2;
  localparam int WB_BR   = 3;

  typedef logic [PTR_W-1:0] rob_ptr_t;
  typedef logic [RT_W-1:0]  rob_rt_t;
  typedef logic [VAL_W-1:0] rob_val_t;
endpackage

// File: rtl/rob_ctrl_if.sv
// rtl/rob_ctrl_if.sv - dispatch / writeback / commit bundle between the pipeline (master) and the ROB (slave)
interface rob_ctrl_if;
  import rob_pkg::*;

  logic [2:0]                  alloc_req;
  rob_rt_t [ALLOC_W-1:0]       alloc_rt;
  logic [2:0]                  alloc_grant;
  rob_ptr_t                    alloc_base_idx;
  logic [NUM_WB-1:0]           wb_valid;
  rob_ptr_t [NUM_WB-1:0]       wb_idx;
  rob_val_t [NUM_WB-1:0]       wb_value;
  logic [ROB_DEPTH-1:0]        rob_output_valid;
  rob_val_t [ROB_DEPTH-1:0]    rob_output_values;
  logic [COMMIT_W-1:0]         commit_valid;
  rob_rt_t [COMMIT_W-1:0]      commit_rt;
  rob_val_t [COMMIT_W-1:0]     commit_value;
  rob_ptr_t [COMMIT_W-1:0]     commit_idx;
  logic                        flush_valid;
  rob_ptr_t                    flush_idx;
  rob_ptr_t                    head_idx;
  rob_ptr_t                    tail_idx;
  logic [CNT_W-1:0]            count;
  logic                        rob_full;
  logic                        rob_empty;

  modport master (
    output alloc_req, alloc_rt, wb_valid, wb_idx, wb_value, flush_valid, flush_idx,
    input  alloc_grant, alloc_base_idx, rob_output_valid, rob_output_values,
    input  commit_valid, commit_rt, commit_value, commit_idx,
    input  head_idx, tail_idx, count, rob_full, rob_empty
  );

  modport slave (
    input  alloc_req, alloc_rt, wb_valid, wb_idx, wb_value, flush_valid, flush_idx,
    output alloc_grant, alloc_base_idx, rob_output_valid, rob_output_values,
    output commit_valid, commit_rt, commit_value, commit_idx,
    output head_idx, tail_idx, count, rob_full, rob_empty
  );
endinterface

// File: rtl/rob_entry_array.sv
// rtl/rob_entry_array.sv - per-entry alloc/done/rt/value storage with allocate, writeback and clear controls
module rob_entry_array
  import rob_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROB_DEPTH-1:0]     alloc_en_i,
  input  rob_rt_t [ROB_DEPTH-1:0]  alloc_rt_i,
  input  logic [ROB_DEPTH-1:0]     clear_en_i,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  rob_ptr_t [NUM_WB-1:0]    wb_idx_i,
  input  rob_val_t [NUM_WB-1:0]    wb_value_i,
  output logic [ROB_DEPTH-1:0]     alloc_o,
  output logic [ROB_DEPTH-1:0]     done_o,
  output rob_rt_t [ROB_DEPTH-1:0]  rt_o,
  output rob_val_t [ROB_DEPTH-1:0] value_o
);
  logic [ROB_DEPTH-1:0]     alloc_q, alloc_d;
  logic [ROB_DEPTH-1:0]     done_q, done_d;
  rob_rt_t [ROB_DEPTH-1:0]  rt_q, rt_d;
  rob_val_t [ROB_DEPTH-1:0] value_q, value_d;

  // Ascending port scan lets the higher-numbered port overwrite on an index collision.
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    rt_d    = rt_q;
    value_d = value_q;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && (wb_idx_i[p] == rob_ptr_t'(e)) && alloc_q[e] && !clear_en_i[e]) begin
          done_d[e]  = 1'b1;
          value_d[e] = wb_value_i[p];
        end
      end
      if (clear_en_i[e]) begin
        alloc_d[e] = 1'b0;
        done_d[e]  = 1'b0;
      end
      if (alloc_en_i[e]) begin
        alloc_d[e] = 1'b1;
        done_d[e]  = 1'b0;
        rt_d[e]    = alloc_rt_i[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      done_q  <= '0;
      rt_q    <= '0;
      value_q <= '0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      rt_q    <= rt_d;
      value_q <= value_d;
    end
  end

  assign alloc_o = alloc_q;
  assign done_o  = done_q;
  assign rt_o    = rt_q;
  assign value_o = value_q;
endmodule

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - 16-entry reorder buffer: 4-wide allocate, 4-port writeback, 2-wide in-order commit
// Optional mispredict flush is built when ROB_FLUSH_EN is defined.
module rob_ctrl
  import rob_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  rob_ctrl_if.slave  bus
);
  logic [CNT_W-1:0]         count_q, count_d;
  rob_ptr_t                 head_q, head_d;
  rob_ptr_t                 tail_q, tail_d;
  logic [ROB_DEPTH-1:0]     ent_alloc, ent_done;
  rob_rt_t [ROB_DEPTH-1:0]  ent_rt;
  rob_val_t [ROB_DEPTH-1:0] ent_value;
  logic [ROB_DEPTH-1:0]     alloc_en, clear_en, kill_en;
  rob_rt_t [ROB_DEPTH-1:0]  alloc_rt_e;
  logic [CNT_W-1:0]         free_cnt, req_sat, grant_w;
  logic [2:0]               grant;
  logic [COMMIT_W-1:0]      commit_v;
  logic [1:0]               n_commit;
  rob_ptr_t                 head_p1;
  logic                     flush_act;

`ifdef ROB_FLUSH_EN
  rob_ptr_t flush_pos;
  assign flush_act = bus.flush_valid;
  assign flush_pos = bus.flush_idx - head_q;

  // Age is measured from head; anything past the branch but inside the occupied window is discarded.
  always_comb begin
    rob_ptr_t pos;
    kill_en = '0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      pos = rob_ptr_t'(e) - head_q;
      if (flush_act && (pos > flush_pos) && ({1'b0, pos} < count_q))
        kill_en[e] = 1'b1;
    end
  end
`else
  wire unused_flush = ^{bus.flush_valid, bus.flush_idx};
  assign flush_act = 1'b0;
  assign kill_en   = '0;
`endif

  always_comb begin
    free_cnt = CNT_W'(ROB_DEPTH) - count_q;
    req_sat  = (bus.alloc_req > 3'd4) ? CNT_W'(ALLOC_W) : {2'b00, bus.alloc_req};
    grant_w  = (req_sat < free_cnt) ? req_sat : free_cnt;
    if (!rst_n || flush_act)
      grant_w = '0;
  end
  assign grant = grant_w[2:0];

  assign head_p1     = head_q + rob_ptr_t'(1);
  assign commit_v[0] = ent_alloc[head_q] & ent_done[head_q];
  assign commit_v[1] = commit_v[0] & ent_alloc[head_p1] & ent_done[head_p1];
  assign n_commit    = {1'b0, commit_v[0]} + {1'b0, commit_v[1]};

  always_comb begin
    alloc_en   = '0;
    alloc_rt_e = '0;
    clear_en   = kill_en;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (3'(k) < grant) begin
        alloc_en[tail_q + rob_ptr_t'(k)]   = 1'b1;
        alloc_rt_e[tail_q + rob_ptr_t'(k)] = bus.alloc_rt[k];
      end
    end
    if (commit_v[0]) clear_en[head_q]  = 1'b1;
    if (commit_v[1]) clear_en[head_p1] = 1'b1;
  end

  always_comb begin
    head_d  = head_q + {2'b00, n_commit};
    tail_d  = tail_q + {1'b0, grant};
    count_d = count_q + {2'b00, grant} - {3'b000, n_commit};
`ifdef ROB_FLUSH_EN
    if (flush_act) begin
      tail_d  = bus.flush_idx + rob_ptr_t'(1);
      count_d = {1'b0, flush_pos} + CNT_W'(1) - {3'b000, n_commit};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  rob_entry_array u_entries (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en_i (alloc_en),
    .alloc_rt_i (alloc_rt_e),
    .clear_en_i (clear_en),
    .wb_valid_i (bus.wb_valid),
    .wb_idx_i   (bus.wb_idx),
    .wb_value_i (bus.wb_value),
    .alloc_o    (ent_alloc),
    .done_o     (ent_done),
    .rt_o       (ent_rt),
    .value_o    (ent_value)
  );

  assign bus.alloc_grant       = grant;
  assign bus.alloc_base_idx    = tail_q;
  assign bus.rob_output_valid  = ent_done;
  assign bus.rob_output_values = ent_value;
  assign bus.commit_valid      = commit_v;
  assign bus.commit_rt[0]      = ent_rt[head_q];
  assign bus.commit_rt[1]      = ent_rt[head_p1];
  assign bus.commit_value[0]   = ent_value[head_q];
  assign bus.commit_value[1]   = ent_value[head_p1];
  assign bus.commit_idx[0]     = head_q;
  assign bus.commit_idx[1]     = head_p1;
  assign bus.head_idx          = head_q;
  assign bus.tail_idx          = tail_q;
  assign bus.count             = count_q;
  assign bus.rob_full          = (count_q == CNT_W'(ROB_DEPTH));
  assign bus.rob_empty         = (count_q == '0);
endmodule

// File: tb/tb_rob_ctrl.sv
// tb/tb_rob_ctrl.sv - directed self-checking bench for rob_ctrl (flush cases built with ROB_FLUSH_EN)
module tb_rob_ctrl;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  rob_ctrl_if bus ();

  rob_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.alloc_req   = '0;
    bus.alloc_rt    = '0;
    bus.wb_valid    = '0;
    bus.wb_idx      = '0;
    bus.wb_value    = '0;
    bus.flush_valid = 1'b0;
    bus.flush_idx   = '0;
  endtask

  task automatic wb(input int p, input int idx, input logic [15:0] v);
    bus.wb_valid[p] = 1'b1;
    bus.wb_idx[p]   = 4'(idx);
    bus.wb_value[p] = v;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    idle_inputs();
    rst_n = 1'b0;
    bus.alloc_req = 3'd3;
    #1;
    expect_eq("rst_grant", bus.alloc_grant, 0);
    expect_eq("rst_empty", bus.rob_empty, 1);
    expect_eq("rst_full", bus.rob_full, 0);
    expect_eq("rst_commit", bus.commit_valid, 0);
    expect_eq("rst_count", bus.count, 0);
    expect_eq("rst_tail", bus.tail_idx, 0);

    @(negedge clk);
    rst_n = 1'b1;
    bus.alloc_rt[0] = 4'd1;
    bus.alloc_rt[1] = 4'd2;
    bus.alloc_rt[2] = 4'd3;
    #1;
    expect_eq("single_grant", bus.alloc_grant, 3);
    expect_eq("single_base", bus.alloc_base_idx, 0);
    tick();
    bus.alloc_req = '0;
    #1;
    expect_eq("single_tail", bus.tail_idx, 3);
    expect_eq("single_count", bus.count, 3);

    wb(WB_FXU0, 1, 16'h00AA);
    tick();
    bus.wb_valid = '0;
    wb(WB_LSU, 0, 16'h0055);
    #1;
    expect_eq("ooo_done1", bus.rob_output_valid[1], 1);
    expect_eq("ooo_no_commit", bus.commit_valid, 0);
    tick();
    bus.wb_valid = '0;
    #1;
    expect_eq("ino_commit_v", bus.commit_valid, 2'b11);
    expect_eq("ino_val0", bus.commit_value[0], 16'h0055);
    expect_eq("ino_val1", bus.commit_value[1], 16'h00AA);
    expect_eq("ino_rt0", bus.commit_rt[0], 1);
    expect_eq("ino_rt1", bus.commit_rt[1], 2);
    expect_eq("ino_idx1", bus.commit_idx[1], 1);
    tick();
    expect_eq("ino_head", bus.head_idx, 2);
    expect_eq("ino_count", bus.count, 1);

    wb(WB_BR, 7, 16'h7777);
    tick();
    bus.wb_valid = '0;
    #1;
    expect_eq("wb_unalloc", bus.rob_output_valid[7], 0);

    bus.alloc_req = 3'd7;
    #1;
    expect_eq("fill_sat_grant", bus.alloc_grant, 4);
    expect_eq("fill_base", bus.alloc_base_idx, 3);
    tick();
    bus.alloc_req = 3'd4;
    tick();
    tick();
    #1;
    expect_eq("fill_partial_grant", bus.alloc_grant, 3);
    expect_eq("fill_partial_base", bus.alloc_base_idx, 15);
    tick();
    #1;
    expect_eq("full_count", bus.count, 16);
    expect_eq("full_flag", bus.rob_full, 1);
    expect_eq("full_tail", bus.tail_idx, 2);
    expect_eq("full_grant", bus.alloc_grant, 0);

    wb(WB_FXU0, 5, 16'h1111);
    wb(WB_BR, 5, 16'h2222);
    wb(WB_FXU1, 2, 16'h0202);
    wb(WB_LSU, 3, 16'h0303);
    tick();
    bus.wb_valid = '0;
    #1;
    expect_eq("conflict_val", bus.rob_output_values[5], 16'h2222);
    expect_eq("full_commit_v", bus.commit_valid, 2'b11);
    expect_eq("full_commit_val0", bus.commit_value[0], 16'h0202);
    expect_eq("full_commit_grant", bus.alloc_grant, 0);
    tick();
    #1;
    expect_eq("after_full_head", bus.head_idx, 4);
    expect_eq("after_full_count", bus.count, 14);
    expect_eq("after_full_grant", bus.alloc_grant, 2);
    expect_eq("after_full_base", bus.alloc_base_idx, 2);
    tick();
    bus.alloc_req = '0;
    #1;
    expect_eq("refill_count", bus.count, 16);

    // Asynchronous reset mid-operation: state must drop before any clock edge.
    rst_n = 1'b0;
    #1;
    expect_eq("async_rst_count", bus.count, 0);
    expect_eq("async_rst_empty", bus.rob_empty, 1);
    expect_eq("async_rst_done", bus.rob_output_valid, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    bus.alloc_req = 3'd4;
    repeat (3) tick();
    bus.alloc_req = 3'd2;
    tick();
    bus.alloc_req = '0;
    for (int b = 0; b < 14; b += 4) begin
      for (int p = 0; p < 4; p++)
        if (b + p < 14) wb(p, b + p, 16'(b + p));
      tick();
      bus.wb_valid = '0;
    end
    cyc = 0;
    while (!bus.rob_empty && cyc < 20) begin
      tick();
      cyc++;
    end
    expect_eq("drain_empty", bus.rob_empty, 1);
    expect_eq("drain_head", bus.head_idx, 14);

    bus.alloc_req   = 3'd2;
    bus.alloc_rt[0] = 4'hE;
    bus.alloc_rt[1] = 4'hF;
    tick();
    bus.alloc_req = 3'd4;
    wb(WB_FXU0, 14, 16'h0E0E);
    wb(WB_FXU1, 15, 16'h0F0F);
    #1;
    expect_eq("wrap_head", bus.head_idx, 14);
    expect_eq("wrap_count", bus.count, 2);
    expect_eq("wrap_grant", bus.alloc_grant, 4);
    expect_eq("wrap_base", bus.alloc_base_idx, 0);
    tick();
    bus.wb_valid  = '0;
    bus.alloc_req = '0;
    #1;
    expect_eq("wrap_count2", bus.count, 6);
    expect_eq("wrap_commit_v", bus.commit_valid, 2'b11);
    expect_eq("wrap_commit_rt1", bus.commit_rt[1], 4'hF);
    expect_eq("wrap_commit_idx1", bus.commit_idx[1], 15);
    tick();
    expect_eq("wrap_head0", bus.head_idx, 0);
    expect_eq("wrap_count3", bus.count, 4);

`ifdef ROB_FLUSH_EN
    do_reset();
    bus.alloc_req = 3'd4;
    tick();
    wb(WB_FXU0, 0, 16'h0100);
    wb(WB_FXU1, 1, 16'h0101);
    tick();
    bus.wb_valid  = '0;
    bus.alloc_req = 3'd2;
    tick();
    bus.alloc_req = '0;
    #1;
    expect_eq("fl_pre_head", bus.head_idx, 2);
    expect_eq("fl_pre_count", bus.count, 8);
    expect_eq("fl_pre_tail", bus.tail_idx, 10);
    bus.flush_valid = 1'b1;
    bus.flush_idx   = 4'd4;
    bus.alloc_req   = 3'd4;
    wb(WB_FXU0, 6, 16'h6666);
    wb(WB_FXU1, 3, 16'h3333);
    #1;
    expect_eq("fl_grant", bus.alloc_grant, 0);
    expect_eq("fl_no_commit", bus.commit_valid, 0);
    tick();
    bus.flush_valid = 1'b0;
    bus.alloc_req   = '0;
    bus.wb_valid    = '0;
    #1;
    expect_eq("fl_tail", bus.tail_idx, 5);
    expect_eq("fl_count", bus.count, 3);
    expect_eq("fl_wb_dropped", bus.rob_output_valid[6], 0);
    expect_eq("fl_wb_kept", bus.rob_output_valid[3], 1);
    wb(WB_LSU, 7, 16'h7777);
    tick();
    bus.wb_valid = '0;
    #1;
    expect_eq("fl_entry7_freed", bus.rob_output_valid[7], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Reorder-buffer controller for the 4-wide dispatch path: owns the 16-entry ROB head/tail pointers, occupancy count and per-entry done/value/rt state. Grants up to 4 allocations per cycle to the instruction buffer (which uses `alloc_base_idx` as the base ROB index for its dispatched instructions). Accepts writebacks from the four functional units (fxu 0, fxu 1, lsu, branch) and retires up to 2 completed entries per cycle, in order, to the register file. Also exports per-entry done/value vectors for operand forwarding.

## Interface
- `ROB_DEPTH`, 16, number of entries; power of two.
- `ALLOC_W`, 4, maximum allocations per cycle.
- `COMMIT_W`, 2, maximum commits per cycle.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alloc_req` in 3: number of entries dispatch requests, 0..4. Values above 4 are treated as 4.
- `alloc_rt` in 4x4: destination registers for requested slots 0..3, in program order.
- `alloc_grant` out 3: number of entries granted this cycle.
- `alloc_base_idx` out 4: ROB index of granted slot 0 (the tail). Slot k is at `alloc_base_idx+k` mod 16.
- `wb_valid` in 4: writeback strobes, indexed fxu0, fxu1, lsu, branch.
- `wb_idx` in 4x4: ROB index written by each writeback port.
- `wb_value` in 4x16: result value for each writeback port.
- `rob_output_valid` out 16: per-entry done bit.
- `rob_output_values` out 16x16: per-entry result value.
- `commit_valid` out 2: commit strobes; bit 1 is asserted only when bit 0 is asserted.
- `commit_rt` out 2x4: destination register of each committing entry.
- `commit_value` out 2x16: value of each committing entry.
- `commit_idx` out 2x4: ROB index of each committing entry.
- `flush_valid` in 1: mispredict flush request.
- `flush_idx` in 4: index of the mispredicted branch entry.
- `head_idx` out 4, `tail_idx` out 4, `count` out 5: ROB pointers and occupancy.
- `rob_full` out 1, `rob_empty` out 1.

## Operation
- **State:** per-entry `alloc`, `done`, `rt`, `value`; `head`, `tail` (4 bits, wrap mod 16); `count` (5 bits, 0..16). The invariant `tail == head + count` mod 16 holds at all times.
- **Allocation:**
  - `free = 16 - count`, computed from the registered count only; same-cycle commits do not free space.
  - `alloc_grant = min(alloc_req, free, 4)`.
  - Granted entries get `alloc=1`, `done=0`, and `rt` from `alloc_rt[k]`.
  - `tail` advances by `alloc_grant`.
- **Writeback:**
  - A writeback sets `done=1` and `value` on its entry.
  - A writeback to an entry with `alloc=0` is ignored.
  - If several ports hit the same index, the highest port wins (branch > lsu > fxu1 > fxu0).
- **Commit:**
  - Slot 0 commits when `alloc[head] & done[head]`.
  - Slot 1 commits when slot 0 commits and `alloc[head+1] & done[head+1]`.
  - Committed entries clear `alloc` and `done`; `head` advances by the number of commits.
- **Count update:** `count_next = count + alloc_grant - commits`.
- **Simultaneous events:** allocation and commit in the same cycle are both applied. A writeback and a commit can never target the same entry in one cycle, because commit requires `done` to be already registered.
- **Full:** when `count == 16`, `alloc_grant = 0`. A full ROB that commits 2 entries grants nothing that cycle and up to 2 the next.
- **Empty:** when `count == 0`, `commit_valid = 0`.

## Timing
- `alloc_grant`, `alloc_base_idx`, `commit_*`, `rob_full` and `rob_empty` are combinational from registered state and `alloc_req`. All state updates on the rising edge.
- Writeback latency: a writeback in cycle N shows `rob_output_valid` in N+1; the entry commits in N+1 at the earliest.
- Allocation latency: an entry allocated in cycle N is visible as `alloc` in N+1.
- **Reset:**
  - `head`, `tail`, `count` are 0; all `alloc`, `done`, `value` and `rt` are 0.
  - `commit_valid` is 0, `rob_empty` is 1, `rob_full` is 0.
  - `alloc_grant` is forced to 0 while `rst_n` is low.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- `ROB_FLUSH_EN` defined:
  - On `flush_valid`, entries younger than `flush_idx` are discarded: their `alloc` and `done` are cleared.
  - `tail` becomes `flush_idx+1`.
  - `count` becomes `((flush_idx - head) mod 16) + 1 - commits`.
  - `alloc_grant` is forced to 0 in the flush cycle.
  - Same-cycle writebacks to discarded entries are dropped.
  - Commits in the flush cycle proceed normally.
  - `flush_idx` must reference an allocated entry; behaviour is undefined otherwise.
- `ROB_FLUSH_EN` undefined: the flush ports remain present and are ignored.

## Structure
- **Package `rob_pkg`:** `ROB_DEPTH`, `PTR_W`=4, `CNT_W`=5, and the writeback port index constants `WB_FXU0`=0, `WB_FXU1`=1, `WB_LSU`=2, `WB_BR`=3.
- **Sub-module `rob_entry_array`:** per-entry `alloc`/`done`/`rt`/`value` storage with allocate, writeback and clear controls.
- **`rob_ctrl` itself:** pointers, count, grant and commit selection.

## Test plan
- **Reset and single op:** reset, then `alloc_req=3` → `alloc_grant=3`, `alloc_base_idx=0`; next cycle `tail=3`, `count=3`.
- **Fill:** allocate 4 per cycle for 4 cycles → `count=16`, `rob_full=1`; a further `alloc_req=4` → `alloc_grant=0`.
- **In-order commit:** writeback idx 1 (value 0x00AA) then idx 0 (value 0x0055) → no commit until idx 0 is done; then `commit_valid=2'b11` with values 0x0055, 0x00AA, and `head` advances by 2.
- **Wrap-around:** `head=14`, `count=2`, `alloc_req=4` → `alloc_base_idx=0`, grant 4; committing entries 14 and 15 makes `head=0`.
- **Writeback conflict:** fxu0 and branch both write idx 5 (0x1111 / 0x2222) → `rob_output_values[5]=0x2222`.
- **Flush (`ROB_FLUSH_EN`):** `head=2`, `count=8`, `flush_idx=4`, no commits → `tail=5`, `count=3`, entries 5..9 have `alloc=0`, `alloc_grant=0` in the flush cycle.
